// File: rtl/context_manager.sv
// ---------------------------------------------------------------------------
// context_manager
//
// Time-slice scheduler front end for a small CPU. A down-counter measures the
// running process's quantum; when it expires the block pulses
// jump_context_exchange so the program counter is redirected to the OS
// handler. In the same cycle the PC the process would have executed next is
// captured into a per-process saved-PC table. While the OS owns the CPU it
// can rewrite table slots and resume any process, which reloads the quantum
// counter.
//
// Ports
//   clock                 system clock, rising edge
//   resetCPU              asynchronous active-low reset
//   HLT                   CPU halted: freezes state, counter, table, pulses
//   next_pc[11:0]         PC the CPU would load at the next edge
//   quantum_load          load quantum_value into the reload register
//   quantum_value[7:0]    time-slice length in cycles (0 disables slicing)
//   restore_req           OS request to resume process proc_id
//   table_wr              OS write of table_data into slot proc_id
//   proc_id[2:0]          slot index for restore_req / table_wr
//   table_data[11:0]      PC value for table_wr
//   jump_context_exchange one-cycle pulse: PC goes to os_address
//   restore_jump          one-cycle pulse: PC loads restore_address
//   restore_address[11:0] saved PC of slot proc_id
//   os_address[11:0]      constant OS handler entry
//   current_proc[2:0]     slot of the running process
//   in_os                 high while the OS handler owns the CPU
// ---------------------------------------------------------------------------
module context_manager #(
    parameter int          NPROC    = 8,
    parameter logic [11:0] OS_ENTRY = 12'd1083
) (
    input  logic        clock,
    input  logic        resetCPU,
    input  logic        HLT,
    input  logic [11:0] next_pc,
    input  logic        quantum_load,
    input  logic [7:0]  quantum_value,
    input  logic        restore_req,
    input  logic        table_wr,
    input  logic [2:0]  proc_id,
    input  logic [11:0] table_data,
    output logic        jump_context_exchange,
    output logic        restore_jump,
    output logic [11:0] restore_address,
    output logic [11:0] os_address,
    output logic [2:0]  current_proc,
    output logic        in_os
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EXCH  = 2'd2,
        OS    = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  reload_reg;
    logic [7:0]  counter_reg, counter_next;
    logic [2:0]  current_proc_reg, current_proc_next;
    logic [11:0] table_reg [NPROC];

    logic             id_valid;
    logic             wr_fire;
    logic [NPROC-1:0] wr_hit;
    logic [NPROC-1:0] cap_hit;

    assign id_valid = (int'(proc_id) < NPROC);
    assign wr_fire  = table_wr && !HLT && id_valid;

    // Per-slot write decode. The expiry capture takes precedence over an OS
    // write to the same slot in the same cycle.
    generate
        for (genvar gi = 0; gi < NPROC; gi++) begin : g_slot
            assign wr_hit[gi]  = wr_fire && (proc_id == 3'(gi));
            assign cap_hit[gi] = jump_context_exchange && (current_proc_reg == 3'(gi));
        end
    endgenerate

    // Next-state and pulse logic. HLT gates every transition and pulse, so a
    // halted CPU sees the block completely frozen (including a pending EXCH).
    always_comb begin
        state_next            = state_reg;
        counter_next          = counter_reg;
        current_proc_next     = current_proc_reg;
        jump_context_exchange = 1'b0;
        restore_jump          = 1'b0;
        if (!HLT) begin
            unique case (state_reg)
                IDLE: ;
                COUNT: begin
                    // Expire on 1 rather than counting down to 0, so a
                    // quantum of N yields exactly N counting cycles.
                    if (counter_reg <= 8'd1) begin
                        state_next = EXCH;
                    end else begin
                        counter_next = counter_reg - 8'd1;
                    end
                end
                EXCH: begin
                    jump_context_exchange = 1'b1;
                    state_next            = OS;
                end
                OS: begin
                    // A simultaneous quantum_load owns the state transition,
                    // so the resume is not acknowledged in that cycle.
                    if (restore_req && id_valid && !quantum_load) begin
                        restore_jump      = 1'b1;
                        current_proc_next = proc_id;
                        counter_next      = reload_reg;
                        state_next        = (reload_reg == 8'd0) ? IDLE : COUNT;
                    end
                end
                default: ;
            endcase
            if (quantum_load) begin
                counter_next = quantum_value;
                state_next   = (quantum_value == 8'd0) ? IDLE : COUNT;
            end
        end
    end

    always_ff @(posedge clock or negedge resetCPU) begin
        if (!resetCPU) begin
            state_reg        <= IDLE;
            counter_reg      <= 8'd0;
            reload_reg       <= 8'd0;
            current_proc_reg <= 3'd0;
        end else begin
            state_reg        <= state_next;
            counter_reg      <= counter_next;
            current_proc_reg <= current_proc_next;
            if (quantum_load && !HLT) begin
                reload_reg <= quantum_value;
            end
        end
    end

    // Saved-PC table. It needs a non-zero reset value, so it is built from
    // flops rather than a RAM.
    always_ff @(posedge clock or negedge resetCPU) begin
        if (!resetCPU) begin
            for (int i = 0; i < NPROC; i++) begin
                table_reg[i] <= 12'd256;
            end
        end else begin
            for (int i = 0; i < NPROC; i++) begin
                if (cap_hit[i]) begin
                    table_reg[i] <= next_pc;
                end else if (wr_hit[i]) begin
                    table_reg[i] <= table_data;
                end
            end
        end
    end

    // Combinational read: a same-cycle write to the slot is seen only after
    // the edge, so the old value is returned.
    assign restore_address = id_valid ? table_reg[proc_id] : 12'd0;
    assign os_address      = OS_ENTRY;
    assign current_proc    = current_proc_reg;
    assign in_os           = (state_reg == OS);

endmodule

// File: tb/tb_context_manager.sv
// ---------------------------------------------------------------------------
// tb_context_manager
//
// Self-checking bench for context_manager. A behavioural model keeps the
// saved-PC table as a plain array, the running slot as an integer, and
// predicts expiry purely from "quantum N => pulse N cycles after the
// load/resume edge, plus any halted cycles". Inputs change #1 after the
// rising edge; outputs are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_context_manager;

    logic        clock;
    logic        resetCPU;
    logic        HLT;
    logic [11:0] next_pc;
    logic        quantum_load;
    logic [7:0]  quantum_value;
    logic        restore_req;
    logic        table_wr;
    logic [2:0]  proc_id;
    logic [11:0] table_data;
    logic        jump_context_exchange;
    logic        restore_jump;
    logic [11:0] restore_address;
    logic [11:0] os_address;
    logic [2:0]  current_proc;
    logic        in_os;

    int checks;
    int errors;

    logic [11:0] model_table [8];
    int          model_cur;
    int          quantum;

    context_manager #(.NPROC(8), .OS_ENTRY(12'd1083)) dut (
        .clock                 (clock),
        .resetCPU              (resetCPU),
        .HLT                   (HLT),
        .next_pc               (next_pc),
        .quantum_load          (quantum_load),
        .quantum_value         (quantum_value),
        .restore_req           (restore_req),
        .table_wr              (table_wr),
        .proc_id               (proc_id),
        .table_data            (table_data),
        .jump_context_exchange (jump_context_exchange),
        .restore_jump          (restore_jump),
        .restore_address       (restore_address),
        .os_address            (os_address),
        .current_proc          (current_proc),
        .in_os                 (in_os)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_table[i] = 12'd256;
        model_cur = 0;
    endtask

    task automatic test_reset();
        resetCPU = 1'b0; HLT = 1'b0; next_pc = 12'd0; quantum_load = 1'b0;
        quantum_value = 8'd0; restore_req = 1'b0; table_wr = 1'b0;
        proc_id = 3'd0; table_data = 12'd0;
        #23;
        checks++;
        if (jump_context_exchange !== 1'b0 || restore_jump !== 1'b0 || in_os !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: jump=%b restore=%b in_os=%b expected 0 0 0",
                     jump_context_exchange, restore_jump, in_os);
        end
        checks++;
        if (current_proc !== 3'd0) begin
            errors++;
            $display("FAIL reset_current_proc: got %0d expected 0", current_proc);
        end
        checks++;
        if (os_address !== 12'd1083) begin
            errors++;
            $display("FAIL os_address: got %0d expected 1083", os_address);
        end
        @(negedge clock);
        resetCPU = 1'b1;
        tick();
        model_reset();
        checks++;
        if (in_os !== 1'b0 || jump_context_exchange !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_os=%b jump=%b expected 0 0", in_os, jump_context_exchange);
        end
        $display("reset: released, table model = 256 in all slots");
    endtask

    task automatic test_expiry();
        int bad;
        quantum = 5;
        next_pc = 12'd300;
        quantum_load = 1'b1; quantum_value = 8'(quantum);
        tick();
        quantum_load = 1'b0;
        for (int k = 1; k <= quantum; k++) begin
            tick();
            checks++;
            if (jump_context_exchange !== (k == quantum) || restore_jump !== 1'b0) begin
                errors++;
                $display("FAIL expiry_timing: cycle %0d jump=%b restore=%b expected jump=%b restore=0",
                         k, jump_context_exchange, restore_jump, (k == quantum));
            end
        end
        tick();
        model_table[model_cur] = 12'd300;
        checks++;
        if (in_os !== 1'b1 || jump_context_exchange !== 1'b0) begin
            errors++;
            $display("FAIL expiry_in_os: in_os=%b jump=%b expected 1 0", in_os, jump_context_exchange);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (jump_context_exchange !== 1'b0 || in_os !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL os_holds: %0d cycles left OS or pulsed, expected 0", bad);
        end
        $display("expiry: quantum 5, pulse after 5 cycles, slot 0 <- 300");
    endtask

    task automatic test_restore();
        logic [11:0] pc;
        table_wr = 1'b1; proc_id = 3'd3; table_data = 12'd512;
        tick();
        table_wr = 1'b0;
        model_table[3] = 12'd512;
        restore_req = 1'b1; proc_id = 3'd3;
        #1;
        checks++;
        if (restore_jump !== 1'b1 || restore_address !== 12'd512 || jump_context_exchange !== 1'b0) begin
            errors++;
            $display("FAIL restore_pulse: restore=%b addr=%0d jump=%b expected 1 512 0",
                     restore_jump, restore_address, jump_context_exchange);
        end
        tick();
        restore_req = 1'b0;
        model_cur = 3;
        checks++;
        if (current_proc !== 3'd3 || in_os !== 1'b0 || restore_jump !== 1'b0) begin
            errors++;
            $display("FAIL restore_state: cur=%0d in_os=%b restore=%b expected 3 0 0",
                     current_proc, in_os, restore_jump);
        end
        pc = 12'($urandom);
        next_pc = pc;
        for (int k = 1; k <= quantum; k++) begin
            tick();
            checks++;
            if (jump_context_exchange !== (k == quantum)) begin
                errors++;
                $display("FAIL restore_reload: cycle %0d jump=%b expected %b",
                         k, jump_context_exchange, (k == quantum));
            end
        end
        tick();
        model_table[model_cur] = pc;
        $display("restore: slot 3 resumed at 512, expiry saved pc %0d", pc);
    endtask

    task automatic test_freeze();
        logic [11:0] pc;
        int bad;
        restore_req = 1'b1; proc_id = 3'd0;
        #1;
        checks++;
        if (restore_address !== model_table[0]) begin
            errors++;
            $display("FAIL restore_slot0: addr=%0d expected %0d", restore_address, model_table[0]);
        end
        tick();
        restore_req = 1'b0;
        model_cur = 0;
        tick(); tick();
        HLT = 1'b1;
        table_wr = 1'b1; proc_id = 3'd5; table_data = 12'd777;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (jump_context_exchange !== 1'b0 || restore_jump !== 1'b0) bad++;
        end
        HLT = 1'b0; table_wr = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_pulses: %0d halted cycles pulsed, expected 0", bad);
        end
        // 2 counted + 10 halted; remaining quantum - 2 cycles to expiry
        for (int k = 1; k <= quantum - 2; k++) begin
            tick();
            checks++;
            if (jump_context_exchange !== (k == quantum - 2)) begin
                errors++;
                $display("FAIL freeze_delay: cycle %0d after halt jump=%b expected %b",
                         k, jump_context_exchange, (k == quantum - 2));
            end
        end
        HLT = 1'b1;
        #1;
        checks++;
        if (jump_context_exchange !== 1'b0) begin
            errors++;
            $display("FAIL halt_in_exch: jump=%b expected 0", jump_context_exchange);
        end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (jump_context_exchange !== 1'b0 || in_os !== 1'b0) bad++;
        end
        HLT = 1'b0;
        #1;
        checks++;
        if (bad != 0 || jump_context_exchange !== 1'b1) begin
            errors++;
            $display("FAIL exch_resume: bad=%0d jump=%b expected 0 1", bad, jump_context_exchange);
        end
        pc = 12'($urandom);
        next_pc = pc;
        tick();
        model_table[model_cur] = pc;
        checks++;
        if (in_os !== 1'b1) begin
            errors++;
            $display("FAIL exch_to_os: in_os=%b expected 1", in_os);
        end
        $display("freeze: 10 halted cycles delayed expiry, EXCH held under HLT");
    endtask

    task automatic test_race();
        logic [11:0] pc;
        restore_req = 1'b1; proc_id = 3'd2;
        #1;
        checks++;
        if (restore_address !== model_table[2]) begin
            errors++;
            $display("FAIL race_read: addr=%0d expected %0d", restore_address, model_table[2]);
        end
        tick();
        restore_req = 1'b0;
        model_cur = 2;
        for (int k = 1; k <= quantum; k++) begin
            tick();
            if (k == 2) begin
                restore_req = 1'b1; proc_id = 3'd6;
                #1;
                checks++;
                if (restore_jump !== 1'b0) begin
                    errors++;
                    $display("FAIL restore_outside_os: restore=%b expected 0", restore_jump);
                end
            end else begin
                restore_req = 1'b0;
            end
            checks++;
            if (jump_context_exchange !== (k == quantum) || current_proc !== 3'(model_cur)) begin
                errors++;
                $display("FAIL race_timing: cycle %0d jump=%b cur=%0d expected %b %0d",
                         k, jump_context_exchange, current_proc, (k == quantum), model_cur);
            end
        end
        pc = 12'($urandom);
        next_pc = pc;
        table_wr = 1'b1; proc_id = 3'd2; table_data = ~pc;
        tick();
        table_wr = 1'b0;
        model_table[2] = pc;
        restore_req = 1'b1; proc_id = 3'd2;
        #1;
        checks++;
        if (restore_address !== model_table[2]) begin
            errors++;
            $display("FAIL race_capture_wins: addr=%0d expected %0d", restore_address, model_table[2]);
        end
        tick();
        restore_req = 1'b0;
        for (int k = 1; k <= quantum; k++) tick();
        pc = 12'($urandom);
        next_pc = pc;
        tick();
        model_table[model_cur] = pc;
        $display("race: EXCH capture beat table_wr on slot 2");
    endtask

    task automatic test_random();
        int s, nw, slot, same;
        logic [11:0] val, pc;
        for (int it = 0; it < 25; it++) begin
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++) begin
                slot = int'($urandom_range(0, 7));
                val = 12'($urandom);
                table_wr = 1'b1; proc_id = 3'(slot); table_data = val;
                tick();
                model_table[slot] = val;
            end
            table_wr = 1'b0;
            s = int'($urandom_range(0, 7));
            same = int'($urandom_range(0, 1));
            val = 12'($urandom);
            restore_req = 1'b1; proc_id = 3'(s);
            table_wr = (same == 1); table_data = val;
            #1;
            checks++;
            if (restore_jump !== 1'b1 || restore_address !== model_table[s]) begin
                errors++;
                $display("FAIL random_restore: it %0d slot %0d restore=%b addr=%0d expected 1 %0d",
                         it, s, restore_jump, restore_address, model_table[s]);
            end
            tick();
            restore_req = 1'b0; table_wr = 1'b0;
            if (same == 1) model_table[s] = val;
            model_cur = s;
            for (int k = 1; k <= quantum; k++) begin
                next_pc = 12'($urandom);
                tick();
                checks++;
                if (jump_context_exchange !== (k == quantum) || restore_jump !== 1'b0) begin
                    errors++;
                    $display("FAIL random_expiry: it %0d cycle %0d jump=%b restore=%b expected %b 0",
                             it, k, jump_context_exchange, restore_jump, (k == quantum));
                end
            end
            pc = 12'($urandom);
            next_pc = pc;
            tick();
            model_table[model_cur] = pc;
            $display("random %0d: resumed slot %0d (same-slot wr=%0d), saved pc %0d", it, s, same, pc);
        end
    endtask

    task automatic test_reset_mid_exch();
        int bad;
        logic [11:0] pc;
        restore_req = 1'b1; proc_id = 3'd4;
        tick();
        restore_req = 1'b0;
        model_cur = 4;
        for (int k = 1; k <= quantum; k++) tick();
        checks++;
        if (jump_context_exchange !== 1'b1) begin
            errors++;
            $display("FAIL mid_exch_setup: jump=%b expected 1", jump_context_exchange);
        end
        next_pc = 12'd1234;
        resetCPU = 1'b0;
        #1;
        checks++;
        if (jump_context_exchange !== 1'b0 || in_os !== 1'b0 || current_proc !== 3'd0) begin
            errors++;
            $display("FAIL mid_exch_reset: jump=%b in_os=%b cur=%0d expected 0 0 0",
                     jump_context_exchange, in_os, current_proc);
        end
        @(posedge clock);
        @(negedge clock);
        resetCPU = 1'b1;
        model_reset();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (jump_context_exchange !== 1'b0 || in_os !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_idle: %0d cycles not idle, expected 0", bad);
        end
        quantum = 1;
        quantum_load = 1'b1; quantum_value = 8'd1;
        tick();
        quantum_load = 1'b0;
        tick();
        checks++;
        if (jump_context_exchange !== 1'b1) begin
            errors++;
            $display("FAIL quantum1_expiry: jump=%b expected 1", jump_context_exchange);
        end
        pc = 12'($urandom);
        next_pc = pc;
        tick();
        model_table[0] = pc;
        for (int s = 1; s < 8; s++) begin
            restore_req = 1'b1; proc_id = 3'(s);
            #1;
            checks++;
            if (restore_address !== model_table[s]) begin
                errors++;
                $display("FAIL table_after_reset: slot %0d addr=%0d expected %0d",
                         s, restore_address, model_table[s]);
            end
            tick();
            restore_req = 1'b0;
            model_cur = s;
            tick();
            pc = 12'($urandom);
            next_pc = pc;
            tick();
            model_table[s] = pc;
        end
        $display("reset mid-EXCH: no pulse, slots 1..7 read back 256");
    endtask

    task automatic test_disabled();
        int pulses;
        quantum_load = 1'b1; quantum_value = 8'd0;
        tick();
        quantum_load = 1'b0;
        pulses = 0;
        for (int k = 0; k < 1000; k++) begin
            next_pc = 12'($urandom);
            tick();
            if (jump_context_exchange !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0 || in_os !== 1'b0) begin
            errors++;
            $display("FAIL disabled: pulses=%0d in_os=%b expected 0 0", pulses, in_os);
        end
        $display("disabled: quantum 0, %0d pulses over 1000 cycles", pulses);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        quantum = 5;
        test_reset();
        test_expiry();
        test_restore();
        test_freeze();
        test_race();
        test_random();
        test_reset_mid_exch();
        test_disabled();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
